// File: rtl/accumulator_controller_pkg.sv
// accumulator_controller_pkg: shared op codes, FSM encoding and datapath width
package accumulator_controller_pkg;
    localparam int ACC_W = 4;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLEAR = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/accumulator_controller_adder_subtractor.sv
// adder_subtractor: 4-bit combinational add (selector=0) or subtract (selector=1)
module adder_subtractor
    import accumulator_controller_pkg::*;
(
    input  logic [ACC_W-1:0] num1,
    input  logic [ACC_W-1:0] num2,
    input  logic             selector,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, num1} + {1'b0, num2 ^ {ACC_W{selector}}} + {{ACC_W{1'b0}}, selector};
endmodule

// File: rtl/accumulator_controller.sv
// accumulator_controller: valid/ready command FSM around a 4-bit accumulator; ACC_SAT_EN enables saturating ADD/SUB
module accumulator_controller
    import accumulator_controller_pkg::*;
#(
    parameter int WIDTH = ACC_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic [CNT_W-1:0] op_count
);
    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] data_q, sum, arith, nxt_acc;
    logic             sub, arith_op, cout, ovf;

    adder_subtractor u_addsub (
        .num1    (out_acc),
        .num2    (data_q),
        .selector(sub),
        .sum     (sum),
        .cout    (cout)
    );

    assign in_ready = (state == IDLE) & ~rst;

    always_comb begin
        sub      = op_q == OP_SUB;
        arith_op = op_q == OP_ADD || sub;
        ovf      = (out_acc[WIDTH-1] ^ sum[WIDTH-1]) & ~(out_acc[WIDTH-1] ^ data_q[WIDTH-1] ^ sub);
`ifdef ACC_SAT_EN
        arith    = ovf ? (out_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum;
`else
        arith    = sum;
`endif
        nxt_acc  = op_q == OP_LOAD ? data_q : arith_op ? arith : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            out_z     <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op_t'(in_op);
                    data_q <= in_data;
                    state  <= EXEC;
                end
                EXEC: begin
                    out_acc   <= nxt_acc;
                    out_c     <= arith_op & cout;
                    out_v     <= arith_op & ovf;
                    out_z     <= nxt_acc == '0;
                    op_count  <= op_count + CNT_W'(1);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accumulator_controller.sv
// tb_accumulator_controller: directed self-checking bench for accumulator_controller
module tb_accumulator_controller;
    import accumulator_controller_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0] in_op = 2'b00;
    logic [3:0] in_data = 4'd0;
    logic       in_ready, out_valid, out_c, out_v, out_z;
    logic [3:0] out_acc;
    logic [7:0] op_count;
    int         pass = 0, total = 0, lat = 0;
    bit         ok;
    time        t_acc, t0;

    accumulator_controller #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_c(out_c), .out_v(out_v), .out_z(out_z), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    // drives one command, then waits (bounded) for its result; garbage on in_* after acceptance
    task automatic run_op(input logic [1:0] op, input logic [3:0] d);
        int n = 0;
        while (!in_ready && n < 10) begin
            step;
            n++;
        end
        in_op = op;
        in_data = d;
        in_valid = 1'b1;
        step;
        t_acc = $time;
        in_valid = 1'b0;
        in_op = OP_CLEAR;
        in_data = 4'hA;
        lat = 0;
        while (!out_valid && lat < 10) begin
            step;
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        step;
        step;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass++;
        total++; if ({out_valid, out_c, out_v, out_z} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {out_valid, out_c, out_v, out_z}); else pass++;
        total++; if ({out_acc, op_count} !== 12'h000) $display("FAIL rst_acc_cnt got acc=%0d cnt=%0d want 0 0", out_acc, op_count); else pass++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else pass++;
    endtask

    task automatic test_load;
        run_op(OP_LOAD, 4'd5);
        total++; if (!(ok && lat == 1)) $display("FAIL load_latency got ok=%0d lat=%0d want 1 1", ok, lat); else pass++;
        total++; if (out_acc !== 4'd5) $display("FAIL load_acc got %0d want 5", out_acc); else pass++;
        total++; if ({out_c, out_v, out_z} !== 3'b000) $display("FAIL load_flags got %b want 000", {out_c, out_v, out_z}); else pass++;
        total++; if (op_count !== 8'd1) $display("FAIL load_cnt got %0d want 1", op_count); else pass++;
    endtask

    task automatic test_add_sub;
        do_reset;
        run_op(OP_LOAD, 4'd3);
        total++; if (out_acc !== 4'd3) $display("FAIL as_load got %0d want 3", out_acc); else pass++;
        run_op(OP_ADD, 4'd4);
        total++; if ({out_acc, out_c, out_v, out_z} !== {4'd7, 3'b000}) $display("FAIL as_add got acc=%0d cvz=%b want 7 000", out_acc, {out_c, out_v, out_z}); else pass++;
        run_op(OP_SUB, 4'd7);
        total++; if ({out_acc, out_c, out_v, out_z} !== {4'd0, 3'b101}) $display("FAIL as_sub got acc=%0d cvz=%b want 0 101", out_acc, {out_c, out_v, out_z}); else pass++;
        total++; if (op_count !== 8'd3) $display("FAIL as_cnt got %0d want 3", op_count); else pass++;
    endtask

    task automatic test_borrow;
        run_op(OP_LOAD, 4'd2);
        run_op(OP_SUB, 4'd3);
        total++; if ({out_acc, out_c, out_v, out_z} !== {4'hF, 3'b000}) $display("FAIL borrow got acc=%h cvz=%b want f 000", out_acc, {out_c, out_v, out_z}); else pass++;
    endtask

    task automatic test_overflow;
        logic [3:0] pos_exp, neg_exp;
`ifdef ACC_SAT_EN
        pos_exp = 4'b0111;
        neg_exp = 4'b1000;
`else
        pos_exp = 4'b1001;
        neg_exp = 4'b0111;
`endif
        run_op(OP_LOAD, 4'd6);
        run_op(OP_ADD, 4'd3);
        total++; if ({out_acc, out_c, out_v, out_z} !== {pos_exp, 3'b010}) $display("FAIL ovf_pos got acc=%b cvz=%b want %b 010", out_acc, {out_c, out_v, out_z}, pos_exp); else pass++;
        run_op(OP_LOAD, 4'd8);
        run_op(OP_SUB, 4'd1);
        total++; if ({out_acc, out_c, out_v, out_z} !== {neg_exp, 3'b110}) $display("FAIL ovf_neg got acc=%b cvz=%b want %b 110", out_acc, {out_c, out_v, out_z}, neg_exp); else pass++;
    endtask

    task automatic test_clear;
        run_op(OP_LOAD, 4'd9);
        run_op(OP_CLEAR, 4'd5);
        total++; if ({out_acc, out_c, out_v, out_z} !== {4'd0, 3'b001}) $display("FAIL clear got acc=%0d cvz=%b want 0 001", out_acc, {out_c, out_v, out_z}); else pass++;
    endtask

    task automatic test_stall;
        do_reset;
        out_ready = 1'b0;
        run_op(OP_LOAD, 4'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_op = OP_CLEAR;
            in_data = 4'd0;
            step;
            total++; if ({out_valid, in_ready, out_acc, op_count} !== {1'b1, 1'b0, 4'd4, 8'd1}) $display("FAIL stall_%0d got v=%b rdy=%b acc=%0d cnt=%0d want 1 0 4 1", i, out_valid, in_ready, out_acc, op_count); else pass++;
        end
        out_ready = 1'b1;
        step;
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_release got v=%b rdy=%b want 0 1", out_valid, in_ready); else pass++;
        step;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_accept got rdy=%b want 0", in_ready); else pass++;
        step;
        total++; if ({out_valid, out_acc, out_z, op_count} !== {1'b1, 4'd0, 1'b1, 8'd2}) $display("FAIL stall_second got v=%b acc=%0d z=%b cnt=%0d want 1 0 1 2", out_valid, out_acc, out_z, op_count); else pass++;
    endtask

    task automatic test_back_to_back;
        do_reset;
        run_op(OP_ADD, 4'd1);
        t0 = t_acc;
        run_op(OP_ADD, 4'd2);
        total++; if (t_acc - t0 != 30) $display("FAIL b2b_period got %0t want 30", t_acc - t0); else pass++;
        run_op(OP_ADD, 4'd3);
        total++; if ({out_acc, op_count} !== {4'd6, 8'd3}) $display("FAIL b2b_result got acc=%0d cnt=%0d want 6 3", out_acc, op_count); else pass++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        run_op(OP_LOAD, 4'd5);
        step;
        in_op = OP_ADD;
        in_data = 4'd1;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        total++; if ({out_valid, out_c, out_v, out_z} !== 4'b0000) $display("FAIL mid_rst_flags got %b want 0000", {out_valid, out_c, out_v, out_z}); else pass++;
        total++; if ({out_acc, op_count} !== 12'h000) $display("FAIL mid_rst_acc_cnt got acc=%0d cnt=%0d want 0 0", out_acc, op_count); else pass++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", in_ready); else pass++;
        step;
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL mid_rst_discard got v=%b rdy=%b want 0 1", out_valid, in_ready); else pass++;
    endtask

    initial begin
        test_reset;
        test_load;
        test_add_sub;
        test_borrow;
        test_overflow;
        test_clear;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
